// File: rtl/stage_if_mt_if.sv
// Bundle of the multithreaded fetch stage's TLB, ID, redirect and refill signals.
interface stage_if_mt_if #(
    parameter int N_THREADS  = 4,
    parameter int LINE_WORDS = 4
);
    localparam int TW = $clog2(N_THREADS);

    logic [31:0]              tlb_vaddr;
    logic [31:0]              tlb_paddr;
    logic                     tlb_miss;

    logic                     id_ready;
    logic                     id_valid;
    logic [31:0]              id_pc;
    logic [31:0]              id_instr;
    logic [TW-1:0]            id_thread;
    logic                     id_itlb_miss;

    logic                     redirect_en;
    logic [TW-1:0]            redirect_thread;
    logic [31:0]              redirect_pc;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [31:0]              mem_req_addr;
    logic                     mem_rsp_valid;
    logic [32*LINE_WORDS-1:0] mem_rsp_data;

    logic [N_THREADS-1:0]     stalled;

    // Fetch stage side.
    modport master (
        output tlb_vaddr, input tlb_paddr, input tlb_miss,
        input id_ready, output id_valid, output id_pc, output id_instr,
        output id_thread, output id_itlb_miss,
        input redirect_en, input redirect_thread, input redirect_pc,
        output mem_req_valid, input mem_req_ready, output mem_req_addr,
        input mem_rsp_valid, input mem_rsp_data,
        output stalled
    );

    // TLB / ID stage / memory side.
    modport slave (
        input tlb_vaddr, output tlb_paddr, output tlb_miss,
        output id_ready, input id_valid, input id_pc, input id_instr,
        input id_thread, input id_itlb_miss,
        output redirect_en, output redirect_thread, output redirect_pc,
        input mem_req_valid, output mem_req_ready, input mem_req_addr,
        output mem_rsp_valid, output mem_rsp_data,
        input stalled
    );
endinterface

// File: rtl/stage_if_mt.sv
// Multithreaded instruction fetch: round-robin thread pick, direct-mapped
// physically tagged I-cache, single outstanding line refill.
module stage_if_mt #(
    parameter int          N_THREADS  = 4,
    parameter int          LINES      = 16,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_1000
) (
    input logic          clk,
    input logic          rst,
    stage_if_mt_if.master bus
);
    localparam int TW   = $clog2(N_THREADS);
    localparam int WB   = $clog2(LINE_WORDS);
    localparam int IB   = $clog2(LINES);
    localparam int OB   = WB + 2;
    localparam int TAGW = 32 - OB - IB;
    localparam int LW   = 32 * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

    state_t               r_state, w_state_next;
    logic [31:0]          r_pc [N_THREADS];
    logic [N_THREADS-1:0] r_stall;
    logic [TW-1:0]        r_rr_last;
    logic [LINES-1:0]     r_valid;
    logic [TAGW-1:0]      r_tag [LINES];
    logic [LW-1:0]        r_data [LINES];
    logic [LW-1:0]        r_line_buf;
    logic [31:0]          r_req_addr;
    logic                 r_id_valid, r_id_itlb_miss;
    logic [31:0]          r_id_pc, r_id_instr;
    logic [TW-1:0]        r_id_thread;

    logic                 w_sel_valid;
    logic [TW-1:0]        w_sel, w_cand;
    logic [31:0]          w_pc_sel, w_instr;
    logic [IB-1:0]        w_idx;
    logic [TAGW-1:0]      w_tag;
    logic [WB-1:0]        w_word;
    logic [LW-1:0]        w_line;
    logic                 w_fetch, w_squash, w_hit;
    logic                 w_do_itlb, w_do_hit, w_do_miss, w_capture;
    logic                 w_unused;

    // Round-robin pick: first non-stalled thread after the last issued one.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            w_cand = r_rr_last + TW'(k);
            if (!w_sel_valid && !r_stall[w_cand]) begin
                w_sel_valid = 1'b1;
                w_sel       = w_cand;
            end
        end
    end

    assign w_pc_sel = r_pc[w_sel];
    assign w_idx    = bus.tlb_paddr[OB +: IB];
    assign w_tag    = bus.tlb_paddr[31 -: TAGW];
    assign w_word   = bus.tlb_paddr[2 +: WB];
    assign w_line   = r_data[w_idx];
    assign w_instr  = w_line[{w_word, 5'b0} +: 32];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused = ^bus.tlb_paddr[1:0];

    // A redirect to the thread being fetched kills that fetch outright.
    assign w_fetch   = bus.id_ready && w_sel_valid;
    assign w_squash  = w_fetch && bus.redirect_en && (bus.redirect_thread == w_sel);
    assign w_do_itlb = w_fetch && !w_squash && bus.tlb_miss;
    assign w_do_hit  = w_fetch && !w_squash && !bus.tlb_miss && w_hit;
    // Misses seen while the line is being written are dropped; the thread retries.
    assign w_do_miss = w_fetch && !w_squash && !bus.tlb_miss && !w_hit && (r_state != S_FILL);
    assign w_capture = w_do_miss && (r_state == S_IDLE);

    // Refill next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_capture)         w_state_next = S_REQ;
            S_REQ:   if (bus.mem_req_ready) w_state_next = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid) w_state_next = S_FILL;
            S_FILL:                         w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    // Refill state, request address and line valid bits.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req_addr <= '0;
            r_valid    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) r_req_addr <= {bus.tlb_paddr[31:OB], {OB{1'b0}}};
            if (r_state == S_FILL) r_valid[r_req_addr[OB +: IB]] <= 1'b1;
        end
    end

    // Cache tag/data arrays and response buffer.
    // NOTE: storage arrays are not reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && bus.mem_rsp_valid) r_line_buf <= bus.mem_rsp_data;
        if (r_state == S_FILL) begin
            r_tag[r_req_addr[OB +: IB]]  <= r_req_addr[31 -: TAGW];
            r_data[r_req_addr[OB +: IB]] <= r_line_buf;
        end
    end

    // Thread PCs, stall bits, round-robin pointer and the registered ID result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < N_THREADS; t++) r_pc[t] <= RESET_PC;
            r_stall        <= '0;
            r_rr_last      <= TW'(N_THREADS - 1);
            r_id_valid     <= 1'b0;
            r_id_itlb_miss <= 1'b0;
            r_id_pc        <= '0;
            r_id_instr     <= '0;
            r_id_thread    <= '0;
        end else begin
            if (bus.id_ready) begin
                r_id_valid <= w_do_itlb || w_do_hit;
                if (w_do_itlb || w_do_hit) begin
                    r_id_pc        <= w_pc_sel;
                    r_id_instr     <= w_do_hit ? w_instr : 32'd0;
                    r_id_thread    <= w_sel;
                    r_id_itlb_miss <= w_do_itlb;
                end
                if (w_sel_valid) r_rr_last <= w_sel;
            end
            if (w_do_hit)  r_pc[w_sel]    <= w_pc_sel + 32'd4;
            if (w_do_miss) r_stall[w_sel] <= 1'b1;
            if (r_state == S_FILL) r_stall <= '0;
            if (bus.redirect_en) begin
                r_pc[bus.redirect_thread]    <= bus.redirect_pc;
                r_stall[bus.redirect_thread] <= 1'b0;
            end
        end
    end

    assign bus.tlb_vaddr     = w_pc_sel;
    assign bus.id_valid      = r_id_valid;
    assign bus.id_pc         = r_id_pc;
    assign bus.id_instr      = r_id_instr;
    assign bus.id_thread     = r_id_thread;
    assign bus.id_itlb_miss  = r_id_itlb_miss;
    assign bus.mem_req_valid = (r_state == S_REQ);
    assign bus.mem_req_addr  = r_req_addr;
    assign bus.stalled       = r_stall;
endmodule

// File: tb/tb_stage_if_mt.sv
// Directed bench for stage_if_mt: cold miss/refill, round-robin hits,
// redirect squash, TLB miss, ID back-pressure and reset during refill.
module tb_stage_if_mt;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    localparam logic [127:0] LINE_A = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    localparam logic [127:0] LINE_B = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

    stage_if_mt_if #(.N_THREADS(4), .LINE_WORDS(4)) bus ();

    stage_if_mt #(
        .N_THREADS(4), .LINES(16), .LINE_WORDS(4), .RESET_PC(32'h0000_1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Identity I-TLB.
    assign bus.tlb_paddr = bus.tlb_vaddr;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect an issued hit on the ID outputs.
    task automatic check_issue(input string tag, input int thr, input logic [31:0] pc,
                               input logic [31:0] instr);
        check({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
        check({tag, "_thread"}, 32'(bus.id_thread), 32'(thr));
        check({tag, "_pc"}, bus.id_pc, pc);
        check({tag, "_instr"}, bus.id_instr, instr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_thr [5];
        logic [31:0] exp_pc  [5];
        logic [31:0] exp_ins [5];

        rst = 1'b0;
        bus.id_ready = 1'b0;
        bus.tlb_miss = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_thread = '0;
        bus.redirect_pc = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state.
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_itlb", 32'(bus.id_itlb_miss), 32'd0);
        check("rst_id_pc", bus.id_pc, 32'd0);
        check("rst_id_instr", bus.id_instr, 32'd0);
        check("rst_id_thread", 32'(bus.id_thread), 32'd0);
        check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_req_addr", bus.mem_req_addr, 32'd0);
        check("rst_stalled", 32'(bus.stalled), 32'd0);
        check("rst_vaddr_t0", bus.tlb_vaddr, 32'h0000_1000);

        // Cold cache: every thread misses on 0x1000, one request only.
        bus.id_ready = 1'b1;
        step();
        check("cold_id_valid", 32'(bus.id_valid), 32'd0);
        check("cold_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("cold_req_addr", bus.mem_req_addr, 32'h0000_1000);
        check("cold_stalled1", 32'(bus.stalled), 32'h1);
        step();
        check("cold_stalled2", 32'(bus.stalled), 32'h3);
        step();
        check("cold_stalled3", 32'(bus.stalled), 32'h7);
        step();
        check("cold_stalled4", 32'(bus.stalled), 32'hF);
        check("cold_req_hold", 32'(bus.mem_req_valid), 32'd1);
        check("cold_addr_hold", bus.mem_req_addr, 32'h0000_1000);
        check("cold_none_valid", 32'(bus.id_valid), 32'd0);

        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = LINE_A;
        step();
        bus.mem_rsp_valid = 1'b0;
        check("fillst_stalled", 32'(bus.stalled), 32'hF);
        step();
        check("fill_stalled", 32'(bus.stalled), 32'h0);
        check("fill_id_valid", 32'(bus.id_valid), 32'd0);

        // Warm line: back-to-back round-robin hits.
        exp_thr = '{0, 1, 2, 3, 0};
        exp_pc  = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        exp_ins = '{32'hA000_0000, 32'hA000_0000, 32'hA000_0000, 32'hA000_0000, 32'hA000_0001};
        for (int i = 0; i < 5; i++) begin
            step();
            check_issue($sformatf("rr%0d", i), exp_thr[i], exp_pc[i], exp_ins[i]);
        end

        // TLB miss on thread 1.
        bus.tlb_miss = 1'b1;
        step();
        bus.tlb_miss = 1'b0;
        check("tlb_valid", 32'(bus.id_valid), 32'd1);
        check("tlb_itlb", 32'(bus.id_itlb_miss), 32'd1);
        check("tlb_instr", bus.id_instr, 32'd0);
        check("tlb_pc", bus.id_pc, 32'h0000_1004);
        check("tlb_thread", 32'(bus.id_thread), 32'd1);
        check("tlb_stalled", 32'(bus.stalled), 32'h0);

        // Redirect thread 2 in the same cycle it is selected.
        bus.redirect_en = 1'b1;
        bus.redirect_thread = 2'd2;
        bus.redirect_pc = 32'h0000_2000;
        step();
        bus.redirect_en = 1'b0;
        check("redir_squash", 32'(bus.id_valid), 32'd0);
        check("redir_next_vaddr", bus.tlb_vaddr, 32'h0000_1004);

        exp_thr = '{3, 0, 1, 0, 0};
        exp_pc  = '{32'h1004, 32'h1008, 32'h1004, 32'h0, 32'h0};
        exp_ins = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0001, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            step();
            check_issue($sformatf("post%0d", i), exp_thr[i], exp_pc[i], exp_ins[i]);
        end
        check("post_itlb_clr", 32'(bus.id_itlb_miss), 32'd0);

        // ID back-pressure holds outputs and pointer.
        bus.id_ready = 1'b0;
        step();
        step();
        check_issue("hold", 1, 32'h0000_1004, 32'hA000_0001);
        check("hold_vaddr", bus.tlb_vaddr, 32'h0000_2000);
        bus.id_ready = 1'b1;

        // Thread 2 misses at 0x2000 while others keep hitting.
        step();
        check("t2miss_valid", 32'(bus.id_valid), 32'd0);
        check("t2miss_stalled", 32'(bus.stalled), 32'h4);
        check("t2miss_req", 32'(bus.mem_req_valid), 32'd1);
        check("t2miss_addr", bus.mem_req_addr, 32'h0000_2000);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check_issue("bg0", 3, 32'h0000_1008, 32'hA000_0002);
        check("bg0_req", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = LINE_B;
        step();
        bus.mem_rsp_valid = 1'b0;
        check_issue("bg1", 0, 32'h0000_100C, 32'hA000_0003);
        step();
        check_issue("bg2", 1, 32'h0000_1008, 32'hA000_0002);
        check("bg2_stalled", 32'(bus.stalled), 32'h0);
        step();
        check_issue("redir_fetch", 2, 32'h0000_2000, 32'hB000_0000);

        // Start a refill, then reset while waiting for the response.
        step();
        check("t3miss_addr", bus.mem_req_addr, 32'h0000_1000);
        check("t3miss_stalled", 32'(bus.stalled), 32'h8);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("inwait_req", 32'(bus.mem_req_valid), 32'd0);
        check("inwait_stalled", 32'(bus.stalled), 32'h9);
        #2 rst = 1'b0;
        #1;
        check("arst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("arst_req_addr", bus.mem_req_addr, 32'd0);
        check("arst_stalled", 32'(bus.stalled), 32'h0);
        check("arst_id_valid", 32'(bus.id_valid), 32'd0);
        check("arst_vaddr", bus.tlb_vaddr, 32'h0000_1000);
        bus.id_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = LINE_A;
        step();
        step();
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp_req", 32'(bus.mem_req_valid), 32'd0);
        check("late_rsp_stalled", 32'(bus.stalled), 32'h0);

        // Cache was not written and every PC is back at 0x1000.
        bus.id_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("rst_pc_t%0d", t), bus.tlb_vaddr, 32'h0000_1000);
            step();
            check($sformatf("rst_miss_t%0d", t), 32'(bus.stalled), 32'((1 << (t + 1)) - 1));
        end
        check("rst_miss_valid", 32'(bus.id_valid), 32'd0);
        check("rst_miss_req", 32'(bus.mem_req_valid), 32'd1);
        check("rst_miss_addr", bus.mem_req_addr, 32'h0000_1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/stage_if_mt.md
STAGE_IF_MT -- requirements
Module: stage_if_mt

Interface
REQ-001 SHALL have parameter N_THREADS, default 4: hardware thread count, power of 2, >=2; TW=log2(N_THREADS).
REQ-002 SHALL have parameter LINES, default 16: direct-mapped I-cache lines, power of 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line, power of 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_1000: reset PC of every thread.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port tlb_vaddr  out  32  PC of the selected thread, to external I-TLB.
REQ-008 SHALL have port tlb_paddr  in  32  same-cycle translation of tlb_vaddr.
REQ-009 SHALL have port tlb_miss  in  1  same-cycle TLB miss.
REQ-010 SHALL have port id_ready  in  1  ID stage accepts a new fetch.
REQ-011 SHALL have port id_valid  out  1  registered fetch result valid.
REQ-012 SHALL have ports id_pc out 32, id_instr out 32, id_thread out TW, id_itlb_miss out 1: registered fetch result.
REQ-013 SHALL have ports redirect_en in 1, redirect_thread in TW, redirect_pc in 32: branch/exception PC overwrite.
REQ-014 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32: line-aligned refill request.
REQ-015 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in 32*LINE_WORDS: refill line, word 0 in LSBs.
REQ-016 SHALL have port stalled  out  N_THREADS  per-thread miss-stall bits.

Function
REQ-017 SHALL hold one PC register and one stall bit per thread.
REQ-018 SHALL select each cycle, when id_ready=1, the next non-stalled thread round-robin after the last issued thread; none selected when all stalled.
REQ-019 SHALL on I-cache hit with no TLB miss present, on the next edge: id_valid=1, id_pc, id_instr, id_thread; selected PC += 4 (mod 2^32, FFFF_FFFC -> 0000_0000).
REQ-020 SHALL on tlb_miss issue id_valid=1, id_itlb_miss=1, id_instr=0, PC unchanged, thread not stalled.
REQ-021 SHALL on cache miss set the thread's stall bit, drive id_valid=0, PC unchanged; if refill FSM is IDLE, capture line-aligned paddr and go REQ.
REQ-022 SHALL implement refill FSM IDLE -> REQ (mem_req_valid=1, addr stable until mem_req_ready=1) -> WAIT (until mem_rsp_valid=1) -> FILL (write data, tag, valid bit) -> IDLE.
REQ-023 SHALL in FILL clear all stall bits and record no new miss that cycle; missed threads retry on their next turn.
REQ-024 SHALL ignore mem_rsp_valid outside WAIT.
REQ-025 SHALL when id_ready=0 hold all id_* outputs, PCs and the round-robin pointer; a miss in progress continues.
REQ-026 SHALL apply redirect_en at the next edge: PC[redirect_thread]=redirect_pc, its stall bit cleared; a same-cycle fetch of that thread is squashed (id_valid=0, PC takes redirect_pc).
REQ-027 SHALL complete a refill whose thread was redirected, then clear stall bits per REQ-023.
REQ-028 SHALL have hit latency exactly 1 cycle from selection to id_valid.

Reset
REQ-029 SHALL on rst=0 asynchronously set: all PCs=RESET_PC, stall bits=0, cache valid bits=0, FSM=IDLE, round-robin pointer so thread 0 is selected first, id_valid=0, id_itlb_miss=0, id_pc=0, id_instr=0, id_thread=0, mem_req_valid=0, mem_req_addr=0.
REQ-030 SHALL abort any refill on reset mid-operation; a later mem_rsp_valid is ignored.

Verification
REQ-031 SHALL cover: reset, id_ready=1, cold cache -> thread 0 misses at 0x1000, mem_req_addr=0x1000, stalled=4'b0001, threads 1-3 miss recorded as stalled, no request until FILL.
REQ-032 SHALL cover: respond line {W3..W0} -> next turn thread 0 id_instr=W0, id_pc=0x1000, PC advances to 0x1004.
REQ-033 SHALL cover: warm line, all threads hit -> id_thread sequence 0,1,2,3,0 with id_valid=1 every cycle.
REQ-034 SHALL cover: redirect_en thread 2 to 0x2000 same cycle thread 2 selected -> id_valid=0 that slot, next thread 2 fetch id_pc=0x2000.
REQ-035 SHALL cover: tlb_miss=1 for thread 1 -> id_itlb_miss=1, id_instr=0, stalled[1]=0, PC unchanged.
REQ-036 SHALL cover: rst=0 during WAIT then mem_rsp_valid=1 -> no cache write, mem_req_valid=0, all PCs=0x1000.
